// File: rtl/id_pkg.sv
// Shared encodings and instruction-field positions for the MIPS decode stage.
package id_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'b00,
    IMM_ZERO = 2'b01,
    IMM_LUI  = 2'b10,
    IMM_RSVD = 2'b11
  } imm_mode_e;

  // Layout of the control word handed to EX: WB [1:0], MEM [4:2], EXE [8:5].
  typedef struct packed {
    logic [3:0] exe;
    logic [2:0] mem;
    logic [1:0] wb;
  } ctrl_t;

  localparam int REG_ZERO = 0;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/id_stage_pipe_if.sv
// ID -> EX pipeline bundle: the ID/EX register contents plus the EX back-pressure.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
) ();
  // valid/ready: a transfer happens on a rising edge where ex_valid & ex_ready;
  // while ex_valid=1 and ex_ready=0 every payload signal holds its value.
  logic              ex_valid;
  logic              ex_ready;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [5:0]        ex_opcode;

  modport master (
    output ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode,
    output ex_ready
  );
endinterface

// File: rtl/id_regfile.sv
// Register file: two read ports and a debug port, all with write-first bypass; R0 is hardwired 0.
module id_regfile
  import id_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_N  = 32,
  localparam int REG_AW = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              dbg_on_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [REG_N];
  logic              wr_en;

  // Debug mode freezes the architectural state, so the bypass is gated too.
  assign wr_en = we_i && !dbg_on_i && (waddr_i != REG_AW'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = (ra_i == REG_AW'(REG_ZERO)) ? '0 :
                      (wr_en && waddr_i == ra_i) ? wdata_i : regs_q[ra_i];
  assign rb_data_o  = (rb_i == REG_AW'(REG_ZERO)) ? '0 :
                      (wr_en && waddr_i == rb_i) ? wdata_i : regs_q[rb_i];
  assign dbg_data_o = (dbg_addr_i == REG_AW'(REG_ZERO)) ? '0 :
                      (wr_en && waddr_i == dbg_addr_i) ? wdata_i : regs_q[dbg_addr_i];

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register read, load-use/branch hazard stall,
// early branch resolution with EX/MEM forwarding, immediate generation, ID/EX register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int REG_N    = 32,
  parameter  int CTRL_W   = 9,
  parameter  int LOAD_LAT = 1,
  localparam int REG_AW   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic [CTRL_W-1:0] ctrl_word,
  input  logic              ctrl_branch,
  input  logic              ctrl_branch_ne,
  input  logic [1:0]        ctrl_imm_mode,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic              mem_mem_read,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_wr_reg,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              dbg_on,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  id_stage_pipe_if.master   ex_if,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush_if
);

  if (DATA_W < 32) begin : g_bad_width
    $error("id_stage_pipe: DATA_W must be >= 32");
  end

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [5:0]        opcode;
  } idex_t;

  idex_t             idex_q, idex_d;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_sext, imm_ext;
  logic [DATA_W-1:0] rs_data, rt_data, br_a, br_b;
  logic              ex_hit, mem_hit, lu, bh, hazard, adv, fwd_ok;

  assign rs_a  = REG_AW'(if_instr[RS_MSB:RS_LSB]);
  assign rt_a  = REG_AW'(if_instr[RT_MSB:RT_LSB]);
  assign rd_a  = REG_AW'(if_instr[RD_MSB:RD_LSB]);
  assign imm16 = if_instr[IMM_MSB:IMM_LSB];

  id_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .dbg_on_i  (dbg_on),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .ra_i      (rs_a),
    .rb_i      (rt_a),
    .dbg_addr_i(dbg_addr),
    .ra_data_o (rs_data),
    .rb_data_o (rt_data),
    .dbg_data_o(dbg_data)
  );

  // rs and rt are both compared whatever the instruction format (conservative).
  assign ex_hit  = (ex_wr_reg != REG_AW'(REG_ZERO)) && (ex_wr_reg == rs_a || ex_wr_reg == rt_a);
  assign mem_hit = (mem_wr_reg != REG_AW'(REG_ZERO)) && (mem_wr_reg == rs_a || mem_wr_reg == rt_a);
  assign lu      = (ex_mem_read && ex_hit) || ((LOAD_LAT == 2) && mem_mem_read && mem_hit);
  assign bh      = ctrl_branch && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));
  assign hazard  = if_valid && (lu || bh);
  assign adv     = ex_if.ex_ready || !idex_q.valid;
  assign id_ready = adv && !hazard;

  // Only an ALU result sitting in EX/MEM can be forwarded to the comparator.
  assign fwd_ok = mem_reg_write && !mem_mem_read && (mem_wr_reg != REG_AW'(REG_ZERO));
  assign br_a   = (fwd_ok && mem_wr_reg == rs_a) ? mem_fwd_data : rs_data;
  assign br_b   = (fwd_ok && mem_wr_reg == rt_a) ? mem_fwd_data : rt_data;

  assign imm_sext      = {{(DATA_W-16){imm16[15]}}, imm16};
  assign branch_target = if_pc + (imm_sext << 2);
  assign branch_taken  = if_valid && ctrl_branch && id_ready && ((br_a == br_b) ^ ctrl_branch_ne);
  assign flush_if      = branch_taken;

  always_comb begin
    imm_ext = '0;
    case (imm_mode_e'(ctrl_imm_mode))
      IMM_SIGN: imm_ext = imm_sext;
      IMM_ZERO: imm_ext = DATA_W'(imm16);
      IMM_LUI:  imm_ext = DATA_W'({imm16, 16'h0000});
      default:  imm_ext = '0;
    endcase
  end

  always_comb begin
    idex_d = idex_q;
    if (adv) begin
      if (if_valid && !hazard) begin
        idex_d.valid   = 1'b1;
        idex_d.ctrl    = ctrl_word;
        idex_d.pc      = if_pc;
        idex_d.rs_data = rs_data;
        idex_d.rt_data = rt_data;
        idex_d.imm     = imm_ext;
        idex_d.rs      = rs_a;
        idex_d.rt      = rt_a;
        idex_d.rd      = rd_a;
        idex_d.opcode  = if_instr[OP_MSB:OP_LSB];
      end else begin
        idex_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign ex_if.ex_valid   = idex_q.valid;
  assign ex_if.ex_ctrl    = idex_q.ctrl;
  assign ex_if.ex_pc      = idex_q.pc;
  assign ex_if.ex_rs_data = idex_q.rs_data;
  assign ex_if.ex_rt_data = idex_q.rt_data;
  assign ex_if.ex_imm     = idex_q.imm;
  assign ex_if.ex_rs      = idex_q.rs;
  assign ex_if.ex_rt      = idex_q.rt;
  assign ex_if.ex_rd      = idex_q.rd;
  assign ex_if.ex_opcode  = idex_q.opcode;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (LOAD_LAT=1 and 2) share stimulus and are
// compared every cycle against a behavioural model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_valid, ctrl_branch, ctrl_branch_ne, wb_we;
  logic [31:0]   if_instr, if_pc, wb_data, mem_fwd_data;
  logic [CW-1:0] ctrl_word;
  logic [1:0]    ctrl_imm_mode;
  logic [AW-1:0] wb_addr, ex_wr_reg, mem_wr_reg, dbg_addr;
  logic          ex_mem_read, ex_reg_write, mem_mem_read, mem_reg_write, dbg_on, ex_ready;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] pc;
    logic [DW-1:0] rsd;
    logic [DW-1:0] rtd;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [5:0]    op;
  } idex_t;

  logic          rdy [2];
  logic          tk  [2];
  logic          fl  [2];
  logic [DW-1:0] tgt [2];
  logic [DW-1:0] dbg [2];
  idex_t         dx  [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    id_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus ();
    assign bus.ex_ready = ex_ready;

    id_stage_pipe #(.DATA_W(DW), .REG_N(NR), .CTRL_W(CW), .LOAD_LAT(k + 1)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(rdy[k]),
      .ctrl_word(ctrl_word), .ctrl_branch(ctrl_branch), .ctrl_branch_ne(ctrl_branch_ne),
      .ctrl_imm_mode(ctrl_imm_mode),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg),
      .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_wr_reg(mem_wr_reg),
      .mem_fwd_data(mem_fwd_data),
      .dbg_on(dbg_on), .dbg_addr(dbg_addr), .dbg_data(dbg[k]),
      .ex_if(bus),
      .branch_taken(tk[k]), .branch_target(tgt[k]), .flush_if(fl[k])
    );

    assign dx[k] = {bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.ex_rs_data, bus.ex_rt_data,
                    bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_opcode};
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] m_rf [NR];
  idex_t         m_ex [2];

  task automatic chk(input string name, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (LOAD_LAT=%0d) got=0x%0h expected=0x%0h at %0t", name, k + 1, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_we && !dbg_on && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic names_src(input logic [AW-1:0] d, input logic [AW-1:0] x, input logic [AW-1:0] y);
    return (d != 0) && (d == x || d == y);
  endfunction

  initial begin : compare
    logic [AW-1:0] rs, rt;
    logic [15:0]   imm;
    logic          lu, bh, hz, adv, e_rdy, e_tk, fwd;
    logic [DW-1:0] a, b, e_imm, e_tgt;
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    m_ex[0] = '0;
    m_ex[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        m_ex[0] = '0;
        m_ex[1] = '0;
      end
      rs  = if_instr[25:21];
      rt  = if_instr[20:16];
      imm = if_instr[15:0];
      fwd = mem_reg_write && !mem_mem_read && mem_wr_reg != 0;
      a   = (fwd && mem_wr_reg == rs) ? mem_fwd_data : m_read(rs);
      b   = (fwd && mem_wr_reg == rt) ? mem_fwd_data : m_read(rt);
      e_tgt = if_pc + {{14{imm[15]}}, imm, 2'b00};
      case (ctrl_imm_mode)
        2'd0:    e_imm = {{16{imm[15]}}, imm};
        2'd1:    e_imm = {16'h0, imm};
        2'd2:    e_imm = {imm, 16'h0};
        default: e_imm = '0;
      endcase
      for (int k = 0; k < 2; k++) begin
        lu = (ex_mem_read && names_src(ex_wr_reg, rs, rt)) ||
             (k == 1 && mem_mem_read && names_src(mem_wr_reg, rs, rt));
        bh = ctrl_branch && ((ex_reg_write && names_src(ex_wr_reg, rs, rt)) ||
                             (mem_mem_read && names_src(mem_wr_reg, rs, rt)));
        hz    = if_valid && (lu || bh);
        adv   = ex_ready || !m_ex[k].v;
        e_rdy = adv && !hz;
        e_tk  = if_valid && ctrl_branch && e_rdy && ((a == b) != ctrl_branch_ne);
        chk("id_ready", k, rdy[k], e_rdy);
        chk("branch_taken", k, tk[k], e_tk);
        chk("flush_if", k, fl[k], e_tk);
        chk("branch_target", k, tgt[k], e_tgt);
        chk("dbg_data", k, dbg[k], m_read(dbg_addr));
        chk("ex_valid", k, dx[k].v, m_ex[k].v);
        chk("ex_ctrl", k, dx[k].ctrl, m_ex[k].ctrl);
        if (m_ex[k].v) begin
          chk("ex_pc", k, dx[k].pc, m_ex[k].pc);
          chk("ex_rs_data", k, dx[k].rsd, m_ex[k].rsd);
          chk("ex_rt_data", k, dx[k].rtd, m_ex[k].rtd);
          chk("ex_imm", k, dx[k].imm, m_ex[k].imm);
          chk("ex_regs", k, {dx[k].rs, dx[k].rt, dx[k].rd}, {m_ex[k].rs, m_ex[k].rt, m_ex[k].rd});
          chk("ex_opcode", k, dx[k].op, m_ex[k].op);
        end
        if (!rst && adv) begin
          if (if_valid && !hz) begin
            m_ex[k].v    = 1'b1;
            m_ex[k].ctrl = ctrl_word;
            m_ex[k].pc   = if_pc;
            m_ex[k].rsd  = m_read(rs);
            m_ex[k].rtd  = m_read(rt);
            m_ex[k].imm  = e_imm;
            m_ex[k].rs   = rs;
            m_ex[k].rt   = rt;
            m_ex[k].rd   = if_instr[15:11];
            m_ex[k].op   = if_instr[31:26];
          end else begin
            m_ex[k] = '0;
          end
        end
      end
      if (!rst && wb_we && !dbg_on && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    if_valid = 0; if_instr = '0; if_pc = '0; ctrl_word = '0;
    ctrl_branch = 0; ctrl_branch_ne = 0; ctrl_imm_mode = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;
    ex_mem_read = 0; ex_reg_write = 0; ex_wr_reg = '0;
    mem_mem_read = 0; mem_reg_write = 0; mem_wr_reg = '0; mem_fwd_data = '0;
    dbg_on = 0; dbg_addr = '0; ex_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    wb_we = 1; wb_addr = a; wb_data = d;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    idle();
    rst = 1;
    repeat (2) step();
    rst = 0;

    // Reset in the middle of a load-use stall with EX holding a valid instruction.
    wr(5'd1, 32'h11);
    idle(); if_valid = 1; if_instr = 32'h00221820; if_pc = 32'h40;
    step();
    ex_ready = 0; ex_mem_read = 1; ex_wr_reg = 5'd1; if_pc = 32'h44;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("stall_ready", k, rdy[k], 1'b0);
      chk("stall_valid", k, dx[k].v, 1'b1);
    end
    step();
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("rst_valid", k, dx[k].v, 1'b0);
    step();
    rst = 0; idle(); dbg_addr = 5'd1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_ready", k, rdy[k], 1'b1);
      chk("post_rst_r1", k, dbg[k], 32'h0);
    end
    step();

    wr(5'd2, 32'h55); wr(5'd4, 32'h66); wr(5'd5, 32'h3); wr(5'd6, 32'h7); wr(5'd8, 32'h88);

    // beq r1,r1,-1 at PC+4=0x100.
    idle(); if_valid = 1; if_instr = 32'h1021FFFF; if_pc = 32'h100; ctrl_branch = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("beq_taken", k, tk[k], 1'b1);
      chk("beq_target", k, tgt[k], 32'hFC);
      chk("beq_flush", k, fl[k], 1'b1);
    end
    step();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("beq_flush_once", k, fl[k], 1'b0);
    step();

    // lw r2 in EX, add r3,r2,r4 in ID.
    idle(); if_valid = 1; if_instr = 32'h00441820; ctrl_word = 9'h003; if_pc = 32'h300;
    ex_mem_read = 1; ex_reg_write = 1; ex_wr_reg = 5'd2;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("lu_ex_ready", k, rdy[k], 1'b0);
    step();
    ex_mem_read = 0; ex_reg_write = 0; ex_wr_reg = '0;
    mem_mem_read = 1; mem_reg_write = 1; mem_wr_reg = 5'd2;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("lu_bubble_valid", k, dx[k].v, 1'b0);
      chk("lu_bubble_ctrl", k, dx[k].ctrl, '0);
    end
    chk("lu_mem_ready", 0, rdy[0], 1'b1);
    chk("lu_mem_ready", 1, rdy[1], 1'b0);
    step();
    mem_mem_read = 0; mem_reg_write = 0; mem_wr_reg = '0;
    wb_we = 1; wb_addr = 5'd2; wb_data = 32'hABCD;
    @(negedge clk);
    chk("lu_issue_valid", 0, dx[0].v, 1'b1);
    chk("lu_issue_rs", 0, dx[0].rsd, 32'h55);
    chk("lu_wait_valid", 1, dx[1].v, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("lu_issue_valid", 1, dx[1].v, 1'b1);
    chk("lu_issue_rs", 1, dx[1].rsd, 32'hABCD);
    chk("lu_issue_rt", 1, dx[1].rtd, 32'h66);
    chk("lu_issue_ctrl", 1, dx[1].ctrl, 9'h003);
    step();

    // bne r5,r6 with r5 forwarded from an ALU op in MEM.
    idle(); if_valid = 1; if_instr = 32'h14A60004; if_pc = 32'h400;
    ctrl_branch = 1; ctrl_branch_ne = 1;
    mem_reg_write = 1; mem_wr_reg = 5'd5; mem_fwd_data = 32'h7;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("bne_fwd_taken", k, tk[k], 1'b0);
      chk("bne_fwd_ready", k, rdy[k], 1'b1);
    end
    step();

    // EX back-pressure for 3 cycles.
    idle(); if_valid = 1; if_instr = 32'h00221820; if_pc = 32'h200;
    step();
    if_pc = 32'h204; ex_ready = 0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("bp_ready", k, rdy[k], 1'b0);
        chk("bp_hold_pc", k, dx[k].pc, 32'h200);
        chk("bp_hold_valid", k, dx[k].v, 1'b1);
      end
      step();
    end
    ex_ready = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("bp_release_ready", k, rdy[k], 1'b1);
    step();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("bp_accept_pc", k, dx[k].pc, 32'h204);
    step();

    // R0 write ignored; debug mode blocks writes.
    idle(); wb_we = 1; wb_addr = 5'd0; wb_data = 32'hDEAD; dbg_addr = 5'd0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("r0_bypass", k, dbg[k], 32'h0);
    step();
    idle(); dbg_addr = 5'd0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("r0_after", k, dbg[k], 32'h0);
    step();
    idle(); dbg_on = 1; wb_we = 1; wb_addr = 5'd8; wb_data = 32'hDEAD; dbg_addr = 5'd8;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("dbg_block_same", k, dbg[k], 32'h88);
    step();
    idle(); dbg_addr = 5'd8;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("dbg_block_after", k, dbg[k], 32'h88);
    step();

    // Randomised traffic, register numbers kept small so hazards and bypasses collide often.
    repeat (2500) begin
      rst            = ($urandom_range(0, 299) == 0);
      if_valid       = ($urandom_range(0, 3) != 0);
      if_instr       = {6'($urandom_range(0, 63)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)), 11'($urandom_range(0, 2047))};
      if_pc          = $urandom() & 32'hFFFF_FFFC;
      ctrl_word      = CW'($urandom_range(0, 511));
      ctrl_branch    = ($urandom_range(0, 2) == 0);
      ctrl_branch_ne = 1'($urandom_range(0, 1));
      ctrl_imm_mode  = 2'($urandom_range(0, 3));
      wb_we          = 1'($urandom_range(0, 1));
      wb_addr        = AW'($urandom_range(0, 7));
      wb_data        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      ex_mem_read    = ($urandom_range(0, 3) == 0);
      ex_reg_write   = 1'($urandom_range(0, 1));
      ex_wr_reg      = AW'($urandom_range(0, 7));
      mem_mem_read   = ($urandom_range(0, 3) == 0);
      mem_reg_write  = 1'($urandom_range(0, 1));
      mem_wr_reg     = AW'($urandom_range(0, 7));
      mem_fwd_data   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      dbg_on         = ($urandom_range(0, 7) == 0);
      dbg_addr       = AW'($urandom_range(0, 7));
      ex_ready       = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the MIPS pipeline, the successor to the fixed 32-bit decode block. It adds a valid/ready handshake on both sides and multi-stage load-use hazard detection. It also resolves branches early in ID, with EX/MEM forwarding, and generates immediates in several modes. It sits between the IF/ID latch and the EX stage, contains the register file, and takes its control word from the external control decoder.

Parameters:
DATA_W, 32, datapath width; must be >= 32 (elaboration error otherwise)
REG_N, 32, register count; REG_AW = clog2(REG_N) is derived
CTRL_W, 9, width of the control word forwarded to EX
LOAD_LAT, 1, load-use stall depth: 1 checks the EX stage only; 2 also checks the MEM stage

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc  in  DATA_W  PC+4 of the instruction
id_ready  out  1  ID accepts the instruction this cycle; drives PC write and IF/ID write
ctrl_word  in  CTRL_W  control word decoded from if_instr
ctrl_branch  in  1  instruction is a conditional branch
ctrl_branch_ne  in  1  1 = bne, 0 = beq
ctrl_imm_mode  in  2  00 sign, 01 zero, 10 lui, 11 reserved
wb_we  in  1  writeback enable
wb_addr  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
ex_mem_read  in  1  instruction in EX is a load
ex_reg_write  in  1  instruction in EX writes a register
ex_wr_reg  in  REG_AW  destination of the instruction in EX
mem_mem_read  in  1  instruction in MEM is a load
mem_reg_write  in  1  instruction in MEM writes a register
mem_wr_reg  in  REG_AW  destination of the instruction in MEM
mem_fwd_data  in  DATA_W  ALU result held in EX/MEM
dbg_on  in  1  debug mode: blocks register-file writes
dbg_addr  in  REG_AW  debug read address
dbg_data  out  DATA_W  debug read data (combinational)
ex_ready  in  1  EX accepts data
ex_valid  out  1  ID/EX holds a valid instruction
ex_ctrl  out  CTRL_W  control word to EX
ex_pc  out  DATA_W  PC+4 passed to EX
ex_rs_data, ex_rt_data  out  DATA_W each  register operands
ex_imm  out  DATA_W  extended immediate
ex_rs, ex_rt, ex_rd  out  REG_AW each  register fields [25:21], [20:16], [15:11], zero-extended
ex_opcode  out  6  instr[31:26]
branch_taken  out  1  combinational; branch resolved taken this cycle
branch_target  out  DATA_W  combinational; if_pc + (sext(imm) << 2), wraps modulo 2^DATA_W
flush_if  out  1  equals branch_taken; IF discards its fetched instruction

Behaviour:
- Reset: all ID/EX outputs, including ex_valid, are 0, and all registers in the file are 0. An in-progress stall is dropped; nothing is replayed.
- Register file: two read ports, one write port, and a debug read port.
  - R0 always reads 0; writes to it are ignored.
  - A write occurs only when wb_we=1 and dbg_on=0.
  - Write-first bypass: a same-cycle write to the addressed register is visible on all read ports.
- Load-use hazard (lu):
  - Raised when ex_mem_read=1, ex_wr_reg!=0, and ex_wr_reg equals rs or rt.
  - If LOAD_LAT=2, also raised when mem_mem_read=1, mem_wr_reg!=0, and mem_wr_reg equals rs or rt.
  - rs and rt are always compared (conservative).
- Branch hazard (bh): ctrl_branch=1 and ex_reg_write=1, ex_wr_reg!=0, ex_wr_reg in {rs, rt}. Also raised when mem_mem_read=1 with a matching mem_wr_reg. Causes a one-cycle stall per blocking stage.
- hazard = if_valid & (lu | bh).
- adv = ex_ready | ~ex_valid.
- id_ready = adv & ~hazard.
- Branch operands: taken from mem_fwd_data when mem_reg_write=1, mem_mem_read=0, mem_wr_reg!=0, and mem_wr_reg matches; otherwise from the register file (with bypass).
- branch_taken = if_valid & ctrl_branch & id_ready & (eq XOR ctrl_branch_ne), where eq compares the two branch operands.
- The branch instruction itself proceeds into EX. Only the IF slot is flushed, so there is exactly one squashed instruction.
- ID/EX register update:
  - If adv=1 and if_valid=1 and hazard=0: load every field; ex_valid=1.
  - If adv=1 and (if_valid=0 or hazard=1): insert a bubble; ex_valid=0, ex_ctrl=0, other fields don't-care but deterministic.
  - If adv=0: hold all fields.
- Immediate generation:
  - sign: sign-extend imm16 to DATA_W.
  - zero: zero-extend imm16.
  - lui: imm16 << 16, zero-extended.
  - reserved: 0.
  - Upper bits beyond 32 follow the same rule.
- Latency: one cycle from acceptance to ex_valid.
- Simultaneous hazard and ex_ready=0: hold; the hazard is re-evaluated each cycle.
- Writeback of a register in the same cycle a stalled instruction reads it: the stalled instruction sees the new value.

Decomposition:
- Package id_pkg holds:
  - IMM_SIGN / IMM_ZERO / IMM_LUI / IMM_RSVD encodings;
  - ctrl_word field slices (WB [1:0], MEM [4:2], EXE [8:5]);
  - the REG_ZERO constant;
  - the opcode field positions.
- Sub-module id_regfile holds the register file (parametrised DATA_W and REG_N, bypass, debug port, dbg_on write block).
- Hazard and branch logic stay in the top module.

Test Plan:
- Reset mid-stall: lu active, assert rst -> ex_valid=0, id_ready=1 after release, and all registers read 0.
- lw r2 in EX, add r3,r2,r4 in ID -> id_ready=0 for 1 cycle (LOAD_LAT=1) or 2 cycles (LOAD_LAT=2); a bubble with ex_ctrl=0 is inserted, then the add issues with the correct r2.
- beq r1,r1 with imm=0xFFFF, if_pc=0x100, no hazard -> branch_taken=1, branch_target=0xFC, flush_if=1 for exactly 1 cycle.
- bne with r5 produced by an ALU op in MEM, mem_fwd_data=7, r6=7 -> uses the forwarded value; branch_taken=0.
- ex_ready=0 for 3 cycles -> all ID/EX outputs stable and id_ready=0; the instruction is accepted on the cycle ex_ready returns.
- wb_we=1, wb_addr=0, data 0xDEAD -> R0 still reads 0. Repeating the write to r8 with dbg_on=1 -> r8 unchanged, and dbg_data for r8 shows the old value.
